// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-stage constants, exception codes and the F/D bundle.
// Used by ifu_fetch and its F/D pipeline register.
package ifu_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam int          IM_WORDS_DEF = 4096;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [4:0]  exc;
  } fd_t;

  function automatic logic addr_err(
    input logic [31:0] pc,
    input logic [31:0] base,
    input logic [32:0] span
  );
    logic [31:0] off;
    off = pc - base;
    return (pc[1:0] != 2'b00) || (pc < base) ||
           ({1'b0, off} >= span);
  endfunction

endpackage

// File: rtl/ifu_fetch_fd_pipe_reg.sv
// F/D pipeline register: reset > flush > stall > load.
// A flush leaves a bubble but keeps the PC so the EPC chain stays defined.
module ifu_fetch_fd_pipe_reg
  import ifu_fetch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic stall,
  input  fd_t  d,
  output fd_t  q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (flush) begin
      q.instr <= '0;
      q.pc    <= d.pc;
      q.valid <= 1'b0;
      q.exc   <= EXC_NONE;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: PC register, IM address, F/D capture.
// Define FETCH_EXC_EN to raise AdEL on misaligned or out-of-window fetch.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter int          IM_WORDS = IM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_pc8,
  output logic        fd_valid,
  output logic [4:0]  fd_exc,
  output logic [31:0] fetch_count
);

`ifdef FETCH_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  localparam logic [32:0] IM_SPAN = 33'(IM_WORDS) * 33'd4;

  logic [31:0] pc;
  logic        err;
  fd_t         fd_d;
  fd_t         fd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (!stall) begin
      pc <= redirect_valid ? redirect_pc : pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (!flush && !stall) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign im_addr = pc;
  assign err     = EXC_EN && addr_err(pc, IM_BASE, IM_SPAN);

  always_comb begin
    fd_d       = '0;
    fd_d.instr = err ? 32'd0 : im_instr;
    fd_d.pc    = pc;
    fd_d.valid = 1'b1;
    fd_d.exc   = err ? EXC_ADEL : EXC_NONE;
  end

  ifu_fetch_fd_pipe_reg u_fd (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .stall (stall),
    .d     (fd_d),
    .q     (fd_q)
  );

  assign fd_instr = fd_q.instr;
  assign fd_pc    = fd_q.pc;
  assign fd_pc8   = fd_q.pc + 32'd8;
  assign fd_valid = fd_q.valid;
  assign fd_exc   = fd_q.exc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: expected F/D state is queued per edge.
// Honours FETCH_EXC_EN the same way the design build does.
module tb_ifu_fetch;

  localparam logic [31:0] MAGIC = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_valid;
  logic [31:0] redirect_pc, im_addr, im_instr;
  logic [31:0] fd_instr, fd_pc, fd_pc8, fetch_count;
  logic        fd_valid;
  logic [4:0]  fd_exc;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [4:0]  exc;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc, m_instr, m_fpc, m_cnt;
  logic        m_valid, m_known;
  logic [4:0]  m_exc;

  ifu_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_addr        (im_addr),
    .im_instr       (im_instr),
    .fd_instr       (fd_instr),
    .fd_pc          (fd_pc),
    .fd_pc8         (fd_pc8),
    .fd_valid       (fd_valid),
    .fd_exc         (fd_exc),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  assign im_instr = im_addr ^ MAGIC;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
`ifdef FETCH_EXC_EN
    return (a[1:0] != 2'b00) || (a < 32'h3000) || (a >= 32'h7000);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input logic r, input logic s, input logic f,
                      input logic rv, input logic [31:0] rp);
    exp_t e;
    exp_t g;
    logic b;
    @(negedge clk);
    reset = r; stall = s; flush = f;
    redirect_valid = rv; redirect_pc = rp;
    #1;
    if (m_known) check("im_addr_pre", im_addr, m_pc);
    if (r) begin
      m_instr = 0; m_fpc = 0; m_valid = 0; m_exc = 0; m_cnt = 0;
      m_pc = 32'h3000;
      m_known = 1'b1;
    end else begin
      b = bad_addr(m_pc);
      if (f) begin
        m_instr = 0; m_fpc = m_pc; m_valid = 0; m_exc = 0;
      end else if (!s) begin
        m_instr = b ? 32'd0 : (m_pc ^ MAGIC);
        m_fpc = m_pc; m_valid = 1;
        m_exc = b ? 5'd4 : 5'd0;
      end
      if (!f && !s) m_cnt = m_cnt + 1;
      if (!s) m_pc = rv ? rp : m_pc + 32'd4;
    end
    e.addr = m_pc; e.instr = m_instr; e.pc = m_fpc;
    e.valid = m_valid; e.exc = m_exc; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check("im_addr", im_addr, g.addr);
    check("fd_instr", fd_instr, g.instr);
    check("fd_pc", fd_pc, g.pc);
    check("fd_pc8", fd_pc8, g.pc + 32'd8);
    check("fd_valid", {31'd0, fd_valid}, {31'd0, g.valid});
    check("fd_exc", {27'd0, fd_exc}, {27'd0, g.exc});
    check("fetch_count", fetch_count, g.cnt);
  endtask

  task automatic run(input logic s, input logic f,
                     input logic rv, input logic [31:0] rp);
    step(1'b0, s, f, rv, rp);
  endtask

  logic [31:0] cnt_snap;
  logic [31:0] rnd;

  initial begin
    reset = 1; stall = 0; flush = 0;
    redirect_valid = 0; redirect_pc = 0;
    m_known = 1'b0;
    m_pc = 0; m_instr = 0; m_fpc = 0; m_cnt = 0;
    m_valid = 0; m_exc = 0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_pc", im_addr, 32'h3000);
    check("rst_pc8", fd_pc8, 32'd8);
    check("rst_cnt", fetch_count, 32'd0);

    run(0, 0, 0, 0);
    check("seq_fd_pc0", fd_pc, 32'h3000);
    check("seq_pc8", fd_pc8, 32'h3008);
    run(0, 0, 0, 0);
    check("seq_addr2", im_addr, 32'h3008);

    cnt_snap = fetch_count;
    run(1, 0, 0, 0);
    run(1, 0, 0, 0);
    check("stall_addr", im_addr, 32'h3008);
    check("stall_fd_pc", fd_pc, 32'h3004);
    check("stall_cnt", fetch_count, cnt_snap);
    run(0, 0, 0, 0);
    check("unstall_fd_pc", fd_pc, 32'h3008);
    check("cnt3", fetch_count, 32'd3);

    run(0, 0, 1, 32'h3100);
    check("redir_addr", im_addr, 32'h3100);
    check("delay_slot", fd_pc, 32'h300C);
    run(0, 0, 0, 0);
    check("redir_fd_pc", fd_pc, 32'h3100);

    run(0, 0, 1, 32'h3010);
    run(1, 0, 1, 32'h3200);
    check("stall_redir", im_addr, 32'h3010);

    run(0, 0, 1, 32'h3020);
    cnt_snap = fetch_count;
    run(1, 1, 0, 0);
    check("flush_valid", {31'd0, fd_valid}, 32'd0);
    check("flush_pc", fd_pc, 32'h3020);
    check("flush_addr", im_addr, 32'h3020);
    check("flush_cnt", fetch_count, cnt_snap);

    run(0, 0, 1, 32'h3002);
    run(0, 0, 0, 0);
    run(0, 0, 1, 32'h7000);
    run(0, 0, 0, 0);
    run(0, 0, 1, 32'h6FFC);
    run(0, 0, 0, 0);
    run(0, 0, 1, 32'h2FFC);
    run(0, 0, 0, 0);
    run(0, 0, 1, 32'hFFFF_FFFC);
    run(0, 0, 0, 0);
    check("wrap", im_addr, 32'h0);
    run(0, 1, 1, 32'h3000);

    for (int i = 0; i < 60; i++) begin
      rnd = $urandom;
      run(rnd[0] & rnd[1], rnd[2] & rnd[3] & rnd[4], rnd[5] & rnd[6],
          32'h3000 + {18'd0, rnd[19:8], 2'b00} + {30'd0, rnd[20], 1'b0});
    end
    step(1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives the word address into the instruction memory.
- Captures the returned instruction word and its PC into the F/D pipeline register.
- Accepts stall from the hazard unit, redirect from the D-stage branch/jump logic, and flush from the exception path. Delay-slot architecture.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- IM_WORDS, 4096, instruction-memory depth in words; the valid window is IM_BASE .. IM_BASE+4*IM_WORDS-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and F/D register.
- flush  in  1  turn the F/D register into a bubble.
- redirect_valid  in  1  branch/jump taken, resolved in D.
- redirect_pc  in  32  target PC.
- im_addr  out  32  current fetch PC, sent to instruction memory (combinational read).
- im_instr  in  32  instruction word returned for im_addr in the same cycle.
- fd_instr  out  32  F/D instruction.
- fd_pc  out  32  F/D PC.
- fd_pc8  out  32  fd_pc+8 (link value for jal/jalr).
- fd_valid  out  1  F/D holds a real instruction.
- fd_exc  out  5  F/D exception code; 0 means none.
- fetch_count  out  32  number of instructions accepted into F/D.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - All state updates on the rising edge of clk. reset dominates everything.
- Reset values:
  - pc=RESET_PC.
  - fd_instr=0, fd_pc=0, fd_valid=0, fd_exc=0, fetch_count=0.
  - fd_pc8 is always fd_pc+8, so it equals 8 after reset.
- im_addr = pc at all times, combinational from the PC register. Zero-latency read: im_instr is valid in the same cycle.
- Next-PC priority per edge, highest first:
  - reset -> RESET_PC
  - stall -> hold
  - redirect_valid -> redirect_pc
  - otherwise -> pc+4
- Redirect while stalled is dropped. The D-stage logic re-asserts it on the next unstalled cycle.
- Delay slot: redirect does not kill the instruction fetched in the same cycle. That instruction is the delay slot and enters F/D normally.
- F/D update per edge, highest first:
  - reset -> clear.
  - flush -> fd_instr=0, fd_valid=0, fd_exc=0; fd_pc=pc so the exception PC chain stays defined.
  - stall -> hold all F/D fields.
  - otherwise -> fd_instr=im_instr, fd_pc=pc, fd_valid=1, fd_exc per the optional feature.
- flush and stall in the same cycle: F/D flushes, PC holds.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- fetch_count increments by 1 on each edge where F/D loads a real instruction (not reset, not flush, not stall). It wraps modulo 2^32.
- Exception instructions still count.

Optional Feature:
- Macro: FETCH_EXC_EN.
- Defined: fetch address error is detected on F/D load.
  - Error condition: pc[1:0]!=0, or pc outside the IM window.
  - On error: fd_exc=5'd4 (AdEL), fd_instr forced to 0 (nop), im_addr still driven, fd_valid=1.
- Undefined: fd_exc is constant 0, and im_instr passes unchanged for any PC.

Decomposition:
- Shared header define.v holds:
  - RESET_PC and IM_BASE constants.
  - Exception codes EXC_NONE=0 and EXC_ADEL=4.
  - The FETCH_EXC_EN switch.
- One natural sub-module: fd_pipe_reg.
  - The F/D register with reset/flush/stall priority.
  - Reused for later stage registers.
- PC logic stays in ifu_fetch.

Test Plan:
- Sequential fetch: reset for 2 cycles, then release.
  - im_addr reads 0x3000, 0x3004, 0x3008 on successive cycles.
  - One cycle later fd_pc follows 0x3000, 0x3004; fd_valid=1; fd_pc8=0x3008 when fd_pc=0x3000; fetch_count=3 after 3 loads.
- Stall: assert stall for 2 cycles while pc=0x3008.
  - im_addr holds 0x3008 and F/D holds fd_pc=0x3004.
  - fetch_count is unchanged.
  - After release, fd_pc=0x3008.
- Redirect with delay slot: at pc=0x300C assert redirect_valid=1, redirect_pc=0x3100.
  - Next cycle: im_addr=0x3100 and fd_pc=0x300C (delay slot kept).
  - Following cycle: fd_pc=0x3100.
- Stall plus redirect in the same cycle: stall=1, redirect_valid=1, redirect_pc=0x3200 at pc=0x3010 -> pc stays 0x3010.
- Flush plus stall in the same cycle at pc=0x3020 -> fd_valid=0, fd_instr=0, fd_pc=0x3020; im_addr stays 0x3020; fetch_count unchanged.
- With FETCH_EXC_EN defined:
  - redirect_pc=0x3002 -> next F/D has fd_exc=4, fd_instr=0.
  - redirect_pc=0x7000 -> fd_exc=4.
  - Without the macro, fd_exc=0 for both.
